// File: rtl/snake_pkg.sv
// Shared types and constants for the snake display frame scanner.
package snake_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;
  localparam int CELLS  = GRID_W * GRID_H;

  localparam logic [2:0] OBJ_NONE   = 3'b000;
  localparam logic [2:0] OBJ_HEAD   = 3'b001;
  localparam logic [2:0] OBJ_BODY   = 3'b010;
  localparam logic [2:0] OBJ_APPLE  = 3'b011;
  localparam logic [2:0] OBJ_BORDER = 3'b100;

  typedef enum logic [1:0] {INIT, SCAN, UPDATE} state_t;

  // Priority encoder: head beats body beats apple beats border.
  function automatic logic [2:0] encode_obj(input logic head, input logic body,
                                            input logic apl, input logic brd);
    logic [2:0] code;
    code = OBJ_NONE;
    if (head)      code = OBJ_HEAD;
    else if (body) code = OBJ_BODY;
    else if (apl)  code = OBJ_APPLE;
    else if (brd)  code = OBJ_BORDER;
    return code;
  endfunction

endpackage

// File: rtl/frame_mem.sv
// Last-drawn object code per grid cell; async read, sync write, async and sync clear.
module frame_mem (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [2:0] wdata,
  output logic [2:0] rdata
);
  import snake_pkg::*;

  logic [2:0] mem [CELLS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= OBJ_NONE;
    end else if (clr) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= OBJ_NONE;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/test_1.sv
// Differential frame scanner: walks the grid, stalls on cells whose object changed.
// state  | meaning
// INIT   | waiting for the initial screen clear to finish
// SCAN   | advancing one cell per clock, comparing against the frame store
// UPDATE | redraw of (x,y) requested, waiting for cmd_done
module test_1
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       snakeHead,
  input  logic       snakeBody,
  input  logic       apple,
  input  logic       border,
  input  logic       mode_pb,
  input  logic       GameOver,
  input  logic       cmd_done,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [2:0] obj_code,
  output logic       diff,
  output logic       enable_loop,
  output logic       en_update,
  output logic       init_cycle,
  output logic       sync_reset
);

  state_t     state, state_nx;
  logic [3:0] x_nx, y_nx, x_adv, y_adv;
  logic       mode_q, go_q;
  logic [2:0] stored;

  assign obj_code   = encode_obj(snakeHead, snakeBody, apple, border);
  assign sync_reset = (mode_pb & ~mode_q) | (GameOver & ~go_q);
  assign diff       = (state == SCAN) && (obj_code != stored);

  // Row-major walk; the last column carries into the row, last row wraps to the top.
  assign x_adv = (x == 4'(GRID_W - 1)) ? 4'd0 : x + 4'd1;
  assign y_adv = (x != 4'(GRID_W - 1)) ? y :
                 (y == 4'(GRID_H - 1)) ? 4'd0 : y + 4'd1;

  frame_mem u_frame_mem (
    .clk   (clk),
    .rst   (nrst),
    .clr   (sync_reset),
    .we    (diff),
    .addr  ({y, x}),
    .wdata (obj_code),
    .rdata (stored)
  );

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state  <= INIT;
      x      <= 4'd0;
      y      <= 4'd0;
      mode_q <= 1'b0;
      go_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      x      <= x_nx;
      y      <= y_nx;
      mode_q <= mode_pb;
      go_q   <= GameOver;
    end
  end

  always_comb begin
    state_nx    = state;
    x_nx        = x;
    y_nx        = y;
    init_cycle  = 1'b0;
    enable_loop = 1'b0;
    en_update   = 1'b0;
    case (state)
      INIT: begin
        init_cycle = 1'b1;
        if (cmd_done) state_nx = SCAN;
      end
      SCAN: begin
        enable_loop = 1'b1;
        if (diff) begin
          state_nx = UPDATE;
        end else begin
          x_nx = x_adv;
          y_nx = y_adv;
        end
      end
      UPDATE: begin
        en_update = 1'b1;
        if (cmd_done) begin
          x_nx     = x_adv;
          y_nx     = y_adv;
          state_nx = SCAN;
        end
      end
      default: state_nx = INIT;
    endcase
    // A restart overrides whatever the current state wanted to do.
    if (sync_reset) begin
      state_nx = INIT;
      x_nx     = 4'd0;
      y_nx     = 4'd0;
    end
  end

endmodule

// File: tb/tb_test_1.sv
// Self-checking bench for test_1 against a cell-index reference model of the scanner.
module tb_test_1;

  logic       clk = 1'b0;
  logic       nrst;
  logic       snakeHead, snakeBody, apple, border;
  logic       mode_pb, GameOver, cmd_done;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       diff, enable_loop, en_update, init_cycle, sync_reset;

  int checks = 0;
  int errors = 0;

  // Game map: 0 none, 1 head, 2 body, 3 apple, 4 border (equal to the expected code).
  int         map [256];
  bit         direct;
  logic [3:0] dflags;   // {head, body, apple, border} when driving flags directly

  // Reference model: phase 0 INIT, 1 SCAN, 2 UPDATE; pos is the row-major cell index.
  int   m_phase, m_pos, m_code;
  int   m_store [192];
  logic m_mode_q, m_go_q;
  bit   m_diff, m_restart;

  always #5 clk = ~clk;

  test_1 dut (
    .clk(clk), .nrst(nrst),
    .snakeHead(snakeHead), .snakeBody(snakeBody), .apple(apple), .border(border),
    .mode_pb(mode_pb), .GameOver(GameOver), .cmd_done(cmd_done),
    .x(x), .y(y), .obj_code(obj_code), .diff(diff),
    .enable_loop(enable_loop), .en_update(en_update),
    .init_cycle(init_cycle), .sync_reset(sync_reset)
  );

  // Game logic answering for whatever cell the scanner presents.
  always_comb begin
    {snakeHead, snakeBody, apple, border} = 4'b0000;
    if (direct) begin
      {snakeHead, snakeBody, apple, border} = dflags;
    end else begin
      case (map[{y, x}])
        1: snakeHead = 1'b1;
        2: snakeBody = 1'b1;
        3: apple     = 1'b1;
        4: border    = 1'b1;
        default: ;
      endcase
    end
  end

  function automatic int enc(input logic [3:0] f);
    if (f[3]) return 1;
    if (f[2]) return 2;
    if (f[1]) return 3;
    if (f[0]) return 4;
    return 0;
  endfunction

  always_comb begin
    m_code    = direct ? enc(dflags) : map[m_pos];
    m_restart = (mode_pb && !m_mode_q) || (GameOver && !m_go_q);
    m_diff    = (m_phase == 1) && (m_code != m_store[m_pos]);
  end

  always @(posedge clk or posedge nrst) begin
    if (nrst) begin
      m_phase <= 0;
      m_pos   <= 0;
      for (int i = 0; i < 192; i++) m_store[i] <= 0;
      m_mode_q <= 1'b0;
      m_go_q   <= 1'b0;
    end else begin
      m_mode_q <= mode_pb;
      m_go_q   <= GameOver;
      if (m_restart) begin
        m_phase <= 0;
        m_pos   <= 0;
        for (int i = 0; i < 192; i++) m_store[i] <= 0;
      end else begin
        case (m_phase)
          0: if (cmd_done) m_phase <= 1;
          1: if (m_diff) begin
               m_store[m_pos] <= m_code;
               m_phase <= 2;
             end else m_pos <= (m_pos + 1) % 192;
          2: if (cmd_done) begin
               m_phase <= 1;
               m_pos   <= (m_pos + 1) % 192;
             end
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd_done();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b1; mode_pb = 0; GameOver = 0; cmd_done = 0; direct = 0; dflags = 0;
    for (int i = 0; i < 256; i++) map[i] = 0;
    repeat (3) tick();
    nrst = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if ({x, y} !== 8'h00) begin
      errors++; $display("FAIL reset_xy: x=%0d y=%0d, required 0,0", x, y);
    end
    checks++;
    if ({init_cycle, enable_loop, en_update, sync_reset, diff} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: init/loop/upd/sync/diff=%b, required 10000",
               {init_cycle, enable_loop, en_update, sync_reset, diff});
    end
  endtask

  task automatic test_encoder();
    logic [3:0] pats [4] = '{4'b1100, 4'b0001, 4'b0000, 4'b0010};
    logic [2:0] want [4] = '{3'b001, 3'b100, 3'b000, 3'b011};
    direct = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dflags = pats[i];
      @(negedge clk);
      checks++;
      if (obj_code !== want[i] || diff !== 1'b0) begin
        errors++;
        $display("FAIL encoder_%0d: flags=%b obj_code=%b diff=%b, required %b diff=0",
                 i, pats[i], obj_code, diff, want[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      dflags = 4'($urandom_range(0, 15));
      @(negedge clk);
      checks++;
      if (obj_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL encoder_rand: flags=%b obj_code=%b, required %0d", dflags, obj_code, m_code);
      end
    end
    direct = 1'b0;
    dflags = 0;
    tick();
  endtask

  task automatic test_stall();
    int n;
    bit found;
    map[4 * 16 + 4] = 1;
    pulse_cmd_done();
    n = 0; found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (en_update) begin n = k; found = 1; break; end
      tick();
    end
    checks++;
    if (!found || n != 69) begin
      errors++; $display("FAIL stall_latency: en_update after %0d cycles (seen=%0d), required 69", n, found);
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (x !== 4'd4 || y !== 4'd4 || en_update !== 1'b1 || enable_loop !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: x=%0d y=%0d upd=%b loop=%b, required 4,4 upd=1 loop=0",
               x, y, en_update, enable_loop);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    @(negedge clk);
    checks++;
    if (x !== 4'd5 || y !== 4'd4 || enable_loop !== 1'b1 || en_update !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume: x=%0d y=%0d loop=%b upd=%b, required 5,4 loop=1 upd=0",
               x, y, enable_loop, en_update);
    end
  endtask

  task automatic test_no_change();
    bit saw_upd = 0, saw_wrap = 0, pos_bad = 0;
    logic [3:0] px = 0, py = 0;
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      if (en_update) saw_upd = 1;
      if (k > 0 && px == 4'd15 && py == 4'd11 && x == 4'd0 && y == 4'd0) saw_wrap = 1;
      if (x !== 4'(m_pos % 16) || y !== 4'(m_pos / 16)) pos_bad = 1;
      px = x; py = y;
      tick();
    end
    checks++;
    if (saw_upd) begin errors++; $display("FAIL no_change_upd: en_update seen=1, required 0"); end
    checks++;
    if (!saw_wrap) begin errors++; $display("FAIL no_change_wrap: wrap 15,11->0,0 seen=0, required 1"); end
    checks++;
    if (pos_bad) begin errors++; $display("FAIL no_change_pos: coordinate diverged from model, required match"); end
  endtask

  task automatic test_restart();
    int nonempty = 0, upd_cnt = 0, bad = 0, wait_cnt = 0, bx = 0, by = 0, bp = 0;
    bit started = 0, prev_upd = 0, done = 0;
    @(negedge clk);
    mode_pb = 1'b1;
    #1;
    checks++;
    if (sync_reset !== 1'b1) begin errors++; $display("FAIL restart_pulse: sync_reset=%b, required 1", sync_reset); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (sync_reset !== 1'b0 || init_cycle !== 1'b1 || x !== 4'd0 || y !== 4'd0 || enable_loop !== 1'b0) begin
      errors++;
      $display("FAIL restart_after: sync=%b init=%b x=%0d y=%0d loop=%b, required 0 1 0 0 0",
               sync_reset, init_cycle, x, y, enable_loop);
    end
    repeat (3) tick();
    mode_pb = 1'b0;
    for (int i = 0; i < 192; i++) begin
      int r = $urandom_range(0, 7);
      map[i] = (r < 4) ? 0 : r - 3;
      if (map[i] != 0) nonempty++;
    end
    pulse_cmd_done();
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (x !== 4'(m_pos % 16) || y !== 4'(m_pos / 16) || en_update !== (m_phase == 2) ||
          enable_loop !== (m_phase == 1) || init_cycle !== (m_phase == 0) ||
          diff !== m_diff || obj_code !== 3'(m_code) || sync_reset !== m_restart) begin
        if (bad == 0) begin bx = x; by = y; bp = m_pos; end
        bad++;
      end
      if (m_pos != 0) started = 1;
      if (started && m_pos == 0 && m_phase == 1) done = 1;
      if (en_update && !prev_upd) begin upd_cnt++; wait_cnt = $urandom_range(0, 3); end
      prev_upd = en_update;
      if (en_update) begin
        cmd_done = (wait_cnt == 0);
        if (wait_cnt > 0) wait_cnt--;
      end else begin
        cmd_done = ($urandom_range(0, 9) == 0);
      end
      @(posedge clk); #1;
      cmd_done = 1'b0;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL random_sweep_timeout: sweep completed=0, required 1"); end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_scan: %0d mismatching cycles, first at x=%0d y=%0d, model cell %0d", bad, bx, by, bp);
    end
    checks++;
    if (upd_cnt != nonempty) begin
      errors++; $display("FAIL restart_redraws: updates=%0d, required %0d", upd_cnt, nonempty);
    end
  endtask

  task automatic test_priority();
    bit found = 0;
    map[20] = (map[20] % 4) + 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (en_update) begin found = 1; break; end
      tick();
    end
    checks++;
    if (!found || x !== 4'd4 || y !== 4'd1) begin
      errors++; $display("FAIL priority_stall: seen=%0d x=%0d y=%0d, required 1 at 4,1", found, x, y);
    end
    GameOver = 1'b1;
    cmd_done = 1'b1;
    #1;
    checks++;
    if (sync_reset !== 1'b1) begin errors++; $display("FAIL priority_pulse: sync_reset=%b, required 1", sync_reset); end
    @(posedge clk); #1;
    cmd_done = 1'b0;
    @(negedge clk);
    checks++;
    if (init_cycle !== 1'b1 || x !== 4'd0 || y !== 4'd0 || en_update !== 1'b0 || sync_reset !== 1'b0) begin
      errors++;
      $display("FAIL priority_init: init=%b x=%0d y=%0d upd=%b sync=%b, required 1 0 0 0 0",
               init_cycle, x, y, en_update, sync_reset);
    end
    tick();
    GameOver = 1'b0;
    @(negedge clk);
    checks++;
    if (sync_reset !== 1'b0) begin errors++; $display("FAIL falling_edge: sync_reset=%b, required 0", sync_reset); end
  endtask

  task automatic test_async_reset();
    int first = -1;
    bit found;
    for (int i = 0; i < 192; i++) if (first < 0 && map[i] != 0) first = i;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_cmd_done();
      found = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (en_update) begin found = 1; break; end
        tick();
      end
      checks++;
      if (!found || {y, x} !== 8'(first)) begin
        errors++;
        $display("FAIL first_redraw_%0d: seen=%0d cell=%0d, required %0d", pass, found, {y, x}, first);
      end
      if (pass == 0) begin
        nrst = 1'b1;
        #1;
        checks++;
        if ({x, y} !== 8'h00 || {init_cycle, enable_loop, en_update, diff} !== 4'b1000) begin
          errors++;
          $display("FAIL async_reset: x=%0d y=%0d init/loop/upd/diff=%b, required 0 0 1000",
                   x, y, {init_cycle, enable_loop, en_update, diff});
        end
        #2;
        nrst = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_encoder();
    test_stall();
    test_no_change();
    test_restart();
    test_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: run still active at time limit, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
